// File: rtl/commit_ctrl_pkg.sv
// Shared definitions for the commit stage: datapath widths, ROB head type
// encodings and commit FSM state encodings.
package commit_ctrl_pkg;

    localparam int REG_IDX_LN = 5;
    localparam int ROB_IDX_LN = 4;
    localparam int WORD       = 32;

    typedef enum logic [1:0] {
        HT_REG    = 2'd0,
        HT_STORE  = 2'd1,
        HT_BRANCH = 2'd2,
        HT_NOP    = 2'd3
    } head_type_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_e;

    // Register writeback happens for REG results and for link-writing branches
    // (JAL/JALR); x0 is never written.
    function automatic logic writes_rd(head_type_e t, logic [REG_IDX_LN-1:0] rd);
        return ((t == HT_REG) || (t == HT_BRANCH)) && (rd != '0);
    endfunction

endpackage

// File: rtl/commit_ctrl.sv
// In-order commit controller: retires the ROB head, writes the regfile,
// hands stores to the LSU, and triggers rollback/flush on branch mispredicts.
module commit_ctrl
    import commit_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  head_vld,
    input  logic                  head_done,
    input  logic [1:0]            head_type,
    input  logic [REG_IDX_LN-1:0] head_rd,
    input  logic [WORD-1:0]       head_val,
    input  logic [ROB_IDX_LN-1:0] head_idx,
    input  logic                  head_mispred,
    input  logic [WORD-1:0]       head_target,

    output logic                  rob_pop,
    output logic                  rob_wr_ena,
    output logic [REG_IDX_LN-1:0] rob_wr_rd,
    output logic [WORD-1:0]       rob_wr_val,
    output logic [ROB_IDX_LN-1:0] rob_wr_idx,
    output logic                  reg_rb,

    output logic                  st_req,
    input  logic                  st_ack,

    output logic                  flush,
    output logic [WORD-1:0]       flush_pc,
    output logic [WORD-1:0]       commit_cnt
);

    state_e     state;
    state_e     state_nxt;
    head_type_e htype;
    logic       commitable;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        htype      = head_type_e'(head_type);
        commitable = (state == S_IDLE) && rdy && head_vld && head_done;
        state_nxt  = state;
        rob_pop    = 1'b0;
        rob_wr_ena = 1'b0;
        rob_wr_rd  = '0;
        rob_wr_val = '0;
        rob_wr_idx = '0;
        reg_rb     = 1'b0;
        flush      = 1'b0;
        flush_pc   = '0;

        // Reset outranks everything, including a commitable head or an ack.
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (commitable) begin
                        if (htype == HT_STORE) begin
                            state_nxt = S_ST_WAIT;
                        end else begin
                            rob_pop    = 1'b1;
                            rob_wr_ena = writes_rd(htype, head_rd);
                            rob_wr_rd  = head_rd;
                            rob_wr_val = head_val;
                            rob_wr_idx = head_idx;
                            // Mispredict only means something on a branch.
                            if ((htype == HT_BRANCH) && head_mispred) begin
                                reg_rb    = 1'b1;
                                flush     = 1'b1;
                                flush_pc  = head_target;
                                state_nxt = S_FLUSH;
                            end
                        end
                    end
                end

                S_ST_WAIT: begin
                    if (rdy && st_ack) begin
                        rob_pop    = 1'b1;
                        rob_wr_rd  = head_rd;
                        rob_wr_val = head_val;
                        rob_wr_idx = head_idx;
                        state_nxt  = S_IDLE;
                    end
                end

                S_FLUSH: begin
                    // One quiet cycle while the ROB and RS clear themselves.
                    if (rdy) begin
                        state_nxt = S_IDLE;
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register here samples the pre-edge values, independent of order.
        if (rst) begin
            state      <= S_IDLE;
            st_req     <= 1'b0;
            commit_cnt <= '0;
        end else begin
            state  <= state_nxt;
            // st_req is high exactly for the cycles spent in ST_WAIT.
            st_req <= (state_nxt == S_ST_WAIT);
            if (rob_pop) begin
                commit_cnt <= commit_cnt + 32'd1;
            end
        end
    end

endmodule
